conv_mem_sequencer: RTL and testbench

Parametrised address and phase sequencer for the 2D-convolution memory subsystem. It generates read and write addresses for three phases on a shared block memory:
- LOAD: image block written from the host.
- PROC: block streamed through the convolver, with latency-compensated write-back.
- READ: results streamed back out to the host.

Successor to the fixed 10-bit, fixed-latency controller. Adds:
- configurable kernel size and convolver latency;
- multi-block rotation with a block index;
- single-cycle change-block pulse;
- explicit write enable;
- optional protocol-error flag.

---
 rtl/conv_mem_sequencer_if.sv | 58 +++++
 rtl/conv_mem_sequencer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_conv_mem_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_mem_sequencer_if
// Bundles the host/convolver-facing signals of conv_mem_sequencer.
//
// Optional feature macro used by the sequencer: CONV_SEQ_ERRFLAG_EN (drives error).
//
// Signals
//   img_length   host -> seq   block length in words
//   load         host -> seq   request LOAD phase
//   sop          host -> seq   start of processing
//   valid        host -> seq   word strobe, rising edge = one word
//   read_add     seq  -> mem   memory read address
//   write_add    seq  -> mem   memory write address
//   wr_en        seq  -> mem   convolver result write enable
//   fms2con_vld  seq  -> conv  valid to convolver
//   sopross      seq  -> host  processing in progress
//   eop          seq  -> host  results ready for readout
//   change_block seq  -> host  one-cycle pulse at end of LOAD or READ
//   block_idx    seq  -> host  current memory block
//   state        seq  -> host  IDLE=0 LOAD=1 PROC=2 DONE=3 READ=4
//   error        seq  -> host  sticky protocol error
//
// Modports
//   master : host / test side (drives requests, observes sequencer)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface conv_mem_sequencer_if #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int NB_BLKIDX  = 2
);
  logic [NB_IMAGE-1:0]   img_length;
  logic                  load;
  logic                  sop;
  logic                  valid;
  logic [NB_ADDRESS-1:0] read_add;
  logic [NB_ADDRESS-1:0] write_add;
  logic                  wr_en;
  logic                  fms2con_vld;
  logic                  sopross;
  logic                  eop;
  logic                  change_block;
  logic [NB_BLKIDX-1:0]  block_idx;
  logic [2:0]            state;
  logic                  error;

  modport master (
    output img_length, load, sop, valid,
    input  read_add, write_add, wr_en, fms2con_vld, sopross, eop,
           change_block, block_idx, state, error
  );

  modport slave (
    input  img_length, load, sop, valid,
    output read_add, write_add, wr_en, fms2con_vld, sopross, eop,
           change_block, block_idx, state, error
  );
endinterface

// File: rtl/conv_mem_sequencer.sv
// ---------------------------------------------------------------------------
// conv_mem_sequencer
// Address and phase sequencer for the 2D-convolution block memory. Three
// phases share one memory block:
//   LOAD : host writes an image block, one word per valid rising edge
//   PROC : block streamed to the convolver; results written back once the
//          convolver pipeline (CONV_LATENCY) has filled
//   READ : results streamed back to the host, one word per valid edge
// Blocks are rotated through NB_BLOCK buffers; block_idx advances at the end
// of every LOAD and READ.
//
// Optional feature: define CONV_SEQ_ERRFLAG_EN to build the sticky protocol
// error flag. Without it, error is tied low.
//
// Ports
//   i_CLK    clock
//   i_reset  synchronous, active-high reset
//   bus      conv_mem_sequencer_if.slave (see interface file for signals)
//
// States
//   state | meaning
//   IDLE  | counters cleared, waiting for load / sop / readout request
//   LOAD  | host writing words, address = word count
//   PROC  | streaming to convolver, delayed write-back of results
//   DONE  | results ready, waiting for sop to drop
//   READ  | host reading results, address = word count
// ---------------------------------------------------------------------------
module conv_mem_sequencer #(
  parameter int NB_ADDRESS   = 10,
  parameter int NB_IMAGE     = 10,
  parameter int CONV_LATENCY = 6,
  parameter int KERNEL_SIZE  = 3,
  parameter int NB_BLOCK     = 4,
  parameter int NB_BLKIDX    = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_reset,
  conv_mem_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PROC = 3'd2,
    ST_DONE = 3'd3,
    ST_READ = 3'd4
  } state_t;

  localparam logic [NB_ADDRESS-1:0] ONE_A    = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS-1:0] KSIZE_A  = NB_ADDRESS'(KERNEL_SIZE);
  localparam logic [NB_ADDRESS-1:0] LAT_A    = NB_ADDRESS'(CONV_LATENCY);
  localparam logic [NB_BLKIDX-1:0]  BLK_ONE  = NB_BLKIDX'(1);
  localparam logic [NB_BLKIDX-1:0]  BLK_LAST = NB_BLKIDX'(NB_BLOCK - 1);

  state_t                state_q;
  state_t                state_nx;

  logic [NB_IMAGE-1:0]   len_q;
  logic [NB_ADDRESS-1:0] cnt_q;
  logic [NB_ADDRESS-1:0] rd_cnt_q;
  logic [NB_ADDRESS-1:0] wr_cnt_q;
  logic                  valid_q;

  logic                  fms2con_vld_q;
  logic                  sopross_q;
  logic                  eop_q;
  logic                  change_block_q;
  logic [NB_BLKIDX-1:0]  block_idx_q;

  logic [NB_ADDRESS-1:0] read_add_c;
  logic [NB_ADDRESS-1:0] write_add_c;
  logic                  wr_en_c;

  // All length arithmetic is modular at address width.
  logic [NB_ADDRESS-1:0] len_a;
  logic [NB_ADDRESS-1:0] len_m1;
  logic [NB_ADDRESS-1:0] len_mk;
  logic [NB_ADDRESS-1:0] read_sat;
  logic                  short_len;
  logic                  valid_edge;
  logic                  proc_wr;
  logic                  last_wr;
  logic                  load_done;
  logic                  read_done;
  logic [NB_BLKIDX-1:0]  block_idx_nx;

  assign len_a      = NB_ADDRESS'(len_q);
  assign len_m1     = len_a - ONE_A;
  assign len_mk     = len_a - KSIZE_A;
  assign read_sat   = len_mk + ONE_A;
  assign short_len  = (len_a < KSIZE_A);
  assign valid_edge = bus.valid & ~valid_q;

  // Write-back starts once the read pointer is CONV_LATENCY ahead; a short
  // block produces no convolver output at all.
  assign proc_wr   = (state_q == ST_PROC) && !short_len && (rd_cnt_q >= LAT_A);
  assign last_wr   = proc_wr && (wr_cnt_q == len_mk);
  assign load_done = (state_q == ST_LOAD) && (cnt_q == len_a) && !bus.load;
  assign read_done = (state_q == ST_READ) && (cnt_q == read_sat);

  assign block_idx_nx = (block_idx_q == BLK_LAST) ? '0 : block_idx_q + BLK_ONE;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        // load and sop together is ambiguous: stay put
        if (bus.load && !bus.sop && !eop_q) begin
          state_nx = ST_LOAD;
        end else if (!bus.load && bus.sop && !eop_q) begin
          state_nx = ST_PROC;
        end else if (!bus.load && !bus.sop && eop_q) begin
          state_nx = ST_READ;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_nx = ST_IDLE;
        end
      end
      ST_PROC: begin
        if (short_len || last_wr) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.sop) begin
          state_nx = ST_IDLE;
        end
      end
      ST_READ: begin
        if (read_done) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: combinational outputs (addresses and write enable)
  // -------------------------------------------------------------------------
  always_comb begin
    read_add_c  = '0;
    write_add_c = '0;
    wr_en_c     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        read_add_c  = cnt_q;
        write_add_c = cnt_q;
      end
      ST_PROC: begin
        read_add_c = rd_cnt_q;
        wr_en_c    = proc_wr;
        if (proc_wr) begin
          write_add_c = wr_cnt_q;
        end
      end
      ST_READ: begin
        read_add_c = cnt_q;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Counters and registered status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    // Edge detector history runs through reset so a level held across reset
    // is not mistaken for a new word.
    valid_q <= bus.valid;
    if (i_reset) begin
      len_q          <= bus.img_length;
      cnt_q          <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      fms2con_vld_q  <= 1'b0;
      sopross_q      <= 1'b0;
      eop_q          <= 1'b0;
      change_block_q <= 1'b0;
      block_idx_q    <= '0;
    end else begin
      change_block_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q    <= '0;
          rd_cnt_q <= '0;
          wr_cnt_q <= '0;
          if (state_nx == ST_LOAD) begin
            len_q <= bus.img_length;
          end
          if (state_nx == ST_PROC) begin
            fms2con_vld_q <= 1'b1;
            sopross_q     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (valid_edge && (cnt_q < len_a)) begin
            cnt_q <= cnt_q + ONE_A;
          end
          if (load_done) begin
            change_block_q <= 1'b1;
            block_idx_q    <= block_idx_nx;
          end
        end
        ST_PROC: begin
          if (rd_cnt_q < len_m1) begin
            rd_cnt_q <= rd_cnt_q + ONE_A;
          end
          if (proc_wr && (wr_cnt_q < len_mk)) begin
            wr_cnt_q <= wr_cnt_q + ONE_A;
          end
          if (short_len || last_wr) begin
            eop_q         <= 1'b1;
            fms2con_vld_q <= 1'b0;
            sopross_q     <= 1'b0;
          end
        end
        ST_READ: begin
          if (valid_edge && (cnt_q < read_sat)) begin
            cnt_q <= cnt_q + ONE_A;
          end
          if (read_done) begin
            change_block_q <= 1'b1;
            eop_q          <= 1'b0;
            block_idx_q    <= block_idx_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Optional sticky protocol-error flag
  // -------------------------------------------------------------------------
`ifdef CONV_SEQ_ERRFLAG_EN
  logic error_q;
  logic err_both;
  logic err_edge;
  logic err_short;

  assign err_both  = (state_q == ST_IDLE) && bus.load && bus.sop;
  assign err_edge  = ((state_q == ST_PROC) || (state_q == ST_DONE)) && valid_edge;
  assign err_short = (state_q == ST_IDLE) && (state_nx == ST_PROC) && short_len;

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      error_q <= 1'b0;
    end else if (err_both || err_edge || err_short) begin
      error_q <= 1'b1;
    end
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.read_add     = read_add_c;
  assign bus.write_add    = write_add_c;
  assign bus.wr_en        = wr_en_c;
  assign bus.fms2con_vld  = fms2con_vld_q;
  assign bus.sopross      = sopross_q;
  assign bus.eop          = eop_q;
  assign bus.change_block = change_block_q;
  assign bus.block_idx    = block_idx_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_conv_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_mem_sequencer
// Directed bench for conv_mem_sequencer: a vector table for a short-block
// pass through every phase, then hand sequences for the full-length LOAD /
// PROC / READ flow, block-index wrap, reset mid-phase and the error flag
// (expected value depends on CONV_SEQ_ERRFLAG_EN).
// ---------------------------------------------------------------------------
module tb_conv_mem_sequencer;

  localparam int NB_ADDRESS = 10;
  localparam int NB_IMAGE   = 10;
  localparam int NB_BLKIDX  = 2;

`ifdef CONV_SEQ_ERRFLAG_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk;
  logic rst;

  conv_mem_sequencer_if #(
    .NB_ADDRESS (NB_ADDRESS),
    .NB_IMAGE   (NB_IMAGE),
    .NB_BLKIDX  (NB_BLKIDX)
  ) bus ();

  conv_mem_sequencer #(
    .NB_ADDRESS   (NB_ADDRESS),
    .NB_IMAGE     (NB_IMAGE),
    .CONV_LATENCY (6),
    .KERNEL_SIZE  (3),
    .NB_BLOCK     (4),
    .NB_BLKIDX    (NB_BLKIDX)
  ) dut (
    .i_CLK   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic rst;
    logic load;
    logic sop;
    logic valid;
    int   len;
    int   st;
    int   rd;
    int   wr;
    int   we;
    int   fms;
    int   spr;
    int   eop;
    int   chg;
    int   blk;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(logic r, logic l, logic s, logic v, int len,
                              int st, int rd, int wr, int we, int fms,
                              int spr, int eop, int chg, int blk);
    vec_t x;
    x.rst = r;  x.load = l; x.sop = s;   x.valid = v; x.len = len;
    x.st = st;  x.rd = rd;  x.wr = wr;   x.we = we;   x.fms = fms;
    x.spr = spr; x.eop = eop; x.chg = chg; x.blk = blk;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, int'(bus.state), 0);
    chk({tag, " read_add"}, int'(bus.read_add), 0);
    chk({tag, " write_add"}, int'(bus.write_add), 0);
    chk({tag, " wr_en"}, int'(bus.wr_en), 0);
    chk({tag, " fms2con_vld"}, int'(bus.fms2con_vld), 0);
    chk({tag, " sopross"}, int'(bus.sopross), 0);
    chk({tag, " eop"}, int'(bus.eop), 0);
    chk({tag, " change_block"}, int'(bus.change_block), 0);
    chk({tag, " block_idx"}, int'(bus.block_idx), 0);
    chk({tag, " error"}, int'(bus.error), 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.img_length = '0;
    bus.load       = 1'b0;
    bus.sop        = 1'b0;
    bus.valid      = 1'b0;

    // Short block (len=2 < kernel): LOAD with saturation, PROC with no
    // writes, DONE, READ whose saturation point wraps to 0, reset.
    //        rst load sop val len  st rd wr we fms spr eop chg blk
    vt[0]  = mk(1, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 0, 2,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 0, 1, 2,   1, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 0, 0, 2,   1, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 1, 0, 1, 2,   1, 2, 2, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, 1, 0, 0, 2,   1, 2, 2, 0, 0, 0, 0, 0, 0);
    vt[6]  = mk(0, 1, 0, 1, 2,   1, 2, 2, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[8]  = mk(0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[9]  = mk(0, 0, 1, 0, 2,   2, 0, 0, 0, 1, 1, 0, 0, 1);
    vt[10] = mk(0, 0, 1, 0, 2,   3, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[11] = mk(0, 0, 1, 0, 2,   3, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[12] = mk(0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[13] = mk(0, 0, 0, 0, 2,   4, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[14] = mk(0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 1, 2);
    vt[15] = mk(0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 0, 2);
    vt[16] = mk(0, 1, 1, 0, 2,   0, 0, 0, 0, 0, 0, 0, 0, 2);
    vt[17] = mk(0, 1, 0, 0, 5,   1, 0, 0, 0, 0, 0, 0, 0, 2);
    vt[18] = mk(1, 1, 0, 0, 5,   0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      rst            = vt[i].rst;
      bus.load       = vt[i].load;
      bus.sop        = vt[i].sop;
      bus.valid      = vt[i].valid;
      bus.img_length = NB_IMAGE'(vt[i].len);
      tick();
      chk($sformatf("vec%0d state", i), int'(bus.state), vt[i].st);
      chk($sformatf("vec%0d read_add", i), int'(bus.read_add), vt[i].rd);
      chk($sformatf("vec%0d write_add", i), int'(bus.write_add), vt[i].wr);
      chk($sformatf("vec%0d wr_en", i), int'(bus.wr_en), vt[i].we);
      chk($sformatf("vec%0d fms2con_vld", i), int'(bus.fms2con_vld), vt[i].fms);
      chk($sformatf("vec%0d sopross", i), int'(bus.sopross), vt[i].spr);
      chk($sformatf("vec%0d eop", i), int'(bus.eop), vt[i].eop);
      chk($sformatf("vec%0d change_block", i), int'(bus.change_block), vt[i].chg);
      chk($sformatf("vec%0d block_idx", i), int'(bus.block_idx), vt[i].blk);
    end

    // Full-length LOAD: len=10, ten words plus one ignored extra edge.
    rst = 1'b1; bus.load = 1'b0; bus.sop = 1'b0; bus.valid = 1'b0;
    bus.img_length = NB_IMAGE'(10);
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    bus.load = 1'b1;
    tick();
    chk("load entry state", int'(bus.state), 1);
    for (int i = 1; i <= 11; i++) begin
      bus.valid = 1'b1;
      tick();
      chk($sformatf("load word%0d write_add", i), int'(bus.write_add), (i > 10) ? 10 : i);
      chk($sformatf("load word%0d read_add", i), int'(bus.read_add), (i > 10) ? 10 : i);
      bus.valid = 1'b0;
      tick();
    end
    chk("load hold state", int'(bus.state), 1);
    chk("load hold change_block", int'(bus.change_block), 0);
    bus.load = 1'b0;
    tick();
    chk("load end state", int'(bus.state), 0);
    chk("load end change_block", int'(bus.change_block), 1);
    chk("load end block_idx", int'(bus.block_idx), 1);
    tick();
    chk("load pulse width", int'(bus.change_block), 0);

    // PROC with len=10: 14 cycles, writes on cycles 6..13.
    bus.sop = 1'b1;
    tick();
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("proc k%0d state", k), int'(bus.state), 2);
      chk($sformatf("proc k%0d read_add", k), int'(bus.read_add), (k > 9) ? 9 : k);
      chk($sformatf("proc k%0d wr_en", k), int'(bus.wr_en), (k >= 6) ? 1 : 0);
      chk($sformatf("proc k%0d write_add", k), int'(bus.write_add), (k >= 6) ? k - 6 : 0);
      chk($sformatf("proc k%0d fms2con_vld", k), int'(bus.fms2con_vld), 1);
      chk($sformatf("proc k%0d eop", k), int'(bus.eop), 0);
      tick();
    end
    chk("proc done state", int'(bus.state), 3);
    chk("proc done eop", int'(bus.eop), 1);
    chk("proc done fms2con_vld", int'(bus.fms2con_vld), 0);
    chk("proc done sopross", int'(bus.sopross), 0);
    chk("proc done wr_en", int'(bus.wr_en), 0);
    tick();
    chk("done waits for sop low", int'(bus.state), 3);

    // READ: 8 results, then change-block and eop clear.
    bus.sop = 1'b0;
    tick();
    chk("done exit state", int'(bus.state), 0);
    chk("done exit eop", int'(bus.eop), 1);
    tick();
    chk("read entry state", int'(bus.state), 4);
    for (int i = 1; i <= 8; i++) begin
      bus.valid = 1'b1;
      tick();
      chk($sformatf("read word%0d read_add", i), int'(bus.read_add), i);
      bus.valid = 1'b0;
      tick();
      if (i < 8) begin
        chk($sformatf("read word%0d state", i), int'(bus.state), 4);
      end
    end
    chk("read end state", int'(bus.state), 0);
    chk("read end change_block", int'(bus.change_block), 1);
    chk("read end eop", int'(bus.eop), 0);
    chk("read end block_idx", int'(bus.block_idx), 2);
    chk("clean flow error", int'(bus.error), 0);

    // Four one-word LOADs from reset: block index 1, 2, 3, 0.
    rst = 1'b1;
    bus.img_length = NB_IMAGE'(1);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bus.load = 1'b1;
      tick();
      bus.valid = 1'b1;
      tick();
      bus.valid = 1'b0;
      bus.load  = 1'b0;
      tick();
      chk($sformatf("wrap%0d change_block", n), int'(bus.change_block), 1);
      chk($sformatf("wrap%0d block_idx", n), int'(bus.block_idx), (n + 1) % 4);
      tick();
    end

    // Reset in the middle of PROC at rd_cnt=4.
    rst = 1'b1;
    bus.img_length = NB_IMAGE'(10);
    tick();
    rst = 1'b0;
    bus.sop = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("mid proc read_add", int'(bus.read_add), 4);
    chk("mid proc sopross", int'(bus.sopross), 1);
    rst = 1'b1;
    tick();
    chk_all_zero("proc abort");

    // Reset while DONE holds eop (short block reaches DONE directly).
    bus.img_length = NB_IMAGE'(2);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("short done state", int'(bus.state), 3);
    chk("short done eop", int'(bus.eop), 1);
    chk("short entry error", int'(bus.error), ERR_EXP);
    rst = 1'b1;
    tick();
    chk("done abort state", int'(bus.state), 0);
    chk("done abort eop", int'(bus.eop), 0);
    chk("done abort error", int'(bus.error), 0);

    // load and sop together in IDLE.
    rst = 1'b0;
    bus.sop  = 1'b1;
    bus.load = 1'b1;
    bus.img_length = NB_IMAGE'(10);
    tick();
    chk("both state", int'(bus.state), 0);
    chk("both error", int'(bus.error), ERR_EXP);
    bus.sop  = 1'b0;
    bus.load = 1'b0;
    tick();
    tick();
    chk("error sticky", int'(bus.error), ERR_EXP);
    chk("both idle state", int'(bus.state), 0);
    rst = 1'b1;
    tick();
    chk("error cleared", int'(bus.error), 0);

    // Valid edge during PROC.
    rst = 1'b0;
    bus.sop = 1'b1;
    tick();
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    tick();
    chk("proc edge error", int'(bus.error), ERR_EXP);
    chk("proc edge state", int'(bus.state), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
